// File: rtl/sa_buf_pkg.sv
// Shared types and constants for the systolic-array shift_buffer controller.
// The macro enables are active-low; the constants keep that polarity in one place.
package sa_buf_pkg;

  localparam int DW_DEF    = 128;
  localparam int AW_DEF    = 5;
  localparam int DEPTH_DEF = 32;

  localparam logic MEM_EN = 1'b0;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    LOADED,
    DRAIN
  } state_t;

endpackage

// File: rtl/shift_buffer_ctrl.sv
// Loads operand rows into the shift_buffer macro and replays them in address
// order, one or more passes, onto a backpressured output stream.
module shift_buffer_ctrl
  import sa_buf_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          start,
  input  logic [3:0]    passes,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done,
  output logic          busy,
  output logic [AW:0]   fill_count,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          RETN,
  input  logic [DW-1:0] Q
);

  localparam logic [AW:0] LAST_WR = (AW+1)'(DEPTH - 1);

  state_t        state_reg, state_next;
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [3:0]    pass_reg, pass_next;
  logic          out_valid_reg, out_valid_next;
  logic          out_last_reg, out_last_next;
  logic          done_reg, done_next;

  logic wr_accept;
  logic rd_issue;
  logic rd_at_end;
  logic beat_accept;

  // Gated by RESET so nothing is accepted or issued while reset is held.
  assign wr_ready    = RESET && (state_reg == IDLE || state_reg == FILL);
  assign wr_accept   = wr_valid && wr_ready;
  assign rd_at_end   = ({1'b0, rd_ptr_reg} == (wr_ptr_reg - 1'b1));
  assign rd_issue    = RESET && (state_reg == DRAIN) && (pass_reg != 4'd0) &&
                       (!out_valid_reg || out_ready);
  assign beat_accept = out_valid_reg && out_ready;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    pass_next      = pass_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE, FILL: begin
        if (wr_accept) begin
          wr_ptr_next = wr_ptr_reg + 1'b1;
          state_next  = (wr_last || wr_ptr_reg == LAST_WR) ? LOADED : FILL;
        end
      end
      LOADED: begin
        if (clear) begin
          state_next  = IDLE;
          wr_ptr_next = '0;
        end else if (start) begin
          state_next  = DRAIN;
          rd_ptr_next = '0;
          pass_next   = (passes == 4'd0) ? 4'd1 : passes;
        end
      end
      DRAIN: begin
        if (rd_issue) begin
          out_valid_next = 1'b1;
          out_last_next  = rd_at_end;
          if (rd_at_end) begin
            rd_ptr_next = '0;
            pass_next   = pass_reg - 4'd1;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
          end
        end else if (beat_accept) begin
          out_valid_next = 1'b0;
          // No pass left to issue, so the beat just taken was the final one.
          if (pass_reg == 4'd0) begin
            out_last_next = 1'b0;
            done_next     = 1'b1;
            state_next    = LOADED;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pass_reg      <= 4'd0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      pass_reg      <= pass_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      done_reg      <= done_next;
    end
  end

  assign CEN  = (wr_accept || rd_issue) ? MEM_EN : ~MEM_EN;
  assign WEN  = wr_accept ? MEM_WR : ~MEM_WR;
  assign A    = wr_accept ? wr_ptr_reg[AW-1:0] : (rd_issue ? rd_ptr_reg : '0);
  assign D    = wr_data;
  assign RETN = 1'b1;

  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;
  assign out_data   = Q;
  assign done       = done_reg;
  assign busy       = (state_reg == FILL) || (state_reg == DRAIN);
  assign fill_count = wr_ptr_reg;

endmodule

// File: tb/tb_shift_buffer_ctrl.sv
// Directed bench for shift_buffer_ctrl with a macro model and a replay scoreboard.
module tb_shift_buffer_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    passes = 4'd0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic          busy;
  logic [AW:0]   fill_count;
  logic          CEN;
  logic          WEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic          RETN;
  logic [DW-1:0] Q;

  shift_buffer_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .start(start), .passes(passes), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .busy(busy), .fill_count(fill_count),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .RETN(RETN), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural macro: synchronous write, registered read, Q held while idle.
  logic [DW-1:0] macro_mem [DEPTH];
  always @(posedge CLK) begin
    if (!CEN && !WEN) macro_mem[A] <= D;
    else if (!CEN && WEN) Q <= macro_mem[A];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what was loaded, and the beats a replay must produce.
  logic [DW-1:0] mdl_rows [$];
  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [DW-1:0] got_q [$];
  bit            chk_en = 1'b0;
  bit            done_due = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  int            beat_no = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      check("done_pulse", done, done_due);
      if (done) check("busy_with_done", busy, 0);
      done_due = 1'b0;
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
      end
      if (out_valid && !out_ready) check("stall_cen", CEN, 1);
      if (out_valid && out_ready) begin
        beat_no++;
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got data %0h expected no beat", out_data);
        end else begin
          check("beat_data", out_data, exp_data_q.pop_front());
          check("beat_last", out_last, exp_last_q.pop_front());
          got_q.push_back(out_data);
          $display("beat %0d data=%0h last=%0b", beat_no, out_data, out_last);
          if (exp_data_q.size() == 0) done_due = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int n, input bit with_last, input int base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(base + i + 1);
      wr_last  = with_last && (i == n - 1);
      #3;
      if (mdl_rows.size() < DEPTH) begin
        check("wr_ready_fill", wr_ready, 1);
        check("wr_cen", CEN, 0);
        check("wr_wen", WEN, 0);
        check("wr_addr", A, DW'(mdl_rows.size()));
        mdl_rows.push_back(wr_data);
      end else begin
        check("wr_ready_full", wr_ready, 0);
        check("wr_cen_full", CEN, 1);
      end
      $display("load row %0d data=%0h", i, wr_data);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_start(input int p);
    int np;
    np = (p == 0) ? 1 : p;
    for (int k = 0; k < np; k++)
      for (int r = 0; r < mdl_rows.size(); r++) begin
        exp_data_q.push_back(mdl_rows[r]);
        exp_last_q.push_back(r == mdl_rows.size() - 1);
      end
    got_q.delete();
    chk_en = 1'b1;
    start  = 1'b1;
    passes = 4'(p);
    tick();
    start = 1'b0;
    $display("start passes=%0d", p);
    #3;
    check("first_issue_cen", CEN, 0);
    check("first_issue_wen", WEN, 1);
    check("first_issue_addr", A, 0);
    check("drain_busy", busy, 1);
  endtask

  // stall_mode 0: out_ready held high; 1: out_ready pattern 1,0,0 repeating.
  task automatic run_drain(input bit stall_mode);
    int k;
    k = 0;
    while (exp_data_q.size() != 0 || done_due) begin
      out_ready = stall_mode ? ((k % 3) == 0) : 1'b1;
      tick();
      k++;
      if (k > 2000) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d beats left expected 0", exp_data_q.size());
        break;
      end
    end
    out_ready = 1'b1;
    tick();
    chk_en = 1'b0;
    #3;
    check("after_drain_busy", busy, 0);
    check("after_drain_done", done, 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    mdl_rows.delete();
    $display("clear");
  endtask

  initial begin
    logic [DW-1:0] ref6 [6];
    ref6 = '{128'h1, 128'h2, 128'h3, 128'h1, 128'h2, 128'h3};

    RESET = 1'b0;
    tick();
    tick();
    #3;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_addr", A, 0);
    check("rst_retn", RETN, 1);
    check("rst_fill", fill_count, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #3;
    check("post_rst_wr_ready", wr_ready, 1);
    tick();

    // Three rows, wr_last on the third.
    load(3, 1'b1, 0);
    #3;
    check("load3_fill", fill_count, 3);
    check("load3_wr_ready", wr_ready, 0);
    check("load3_busy", busy, 0);
    tick();

    // Two passes at full rate; pin the exact beat sequence.
    do_start(2);
    run_drain(1'b0);
    check("two_pass_beats", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check("two_pass_literal", got_q[i], ref6[i]);

    // Same contents replayed under backpressure.
    do_start(1);
    run_drain(1'b1);
    check("stall_pass_beats", got_q.size(), 3);

    // start outside LOADED is ignored.
    pulse_clear();
    #3;
    check("clear_fill", fill_count, 0);
    check("clear_wr_ready", wr_ready, 1);
    tick();
    start = 1'b1;
    passes = 4'd1;
    tick();
    start = 1'b0;
    #3;
    check("idle_start_busy", busy, 0);
    check("idle_start_cen", CEN, 1);
    tick();
    check("idle_start_valid", out_valid, 0);

    // Single row reload, then passes=0 gives exactly one pass.
    load(1, 1'b1, 32'h3f);
    #3;
    check("reload_fill", fill_count, 1);
    tick();
    do_start(0);
    run_drain(1'b0);
    check("pass0_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("pass0_literal", got_q[0], 128'h40);

    // Overfill: 33 rows without wr_last, only 32 stored.
    pulse_clear();
    load(33, 1'b0, 32'h100);
    #3;
    check("full_fill", fill_count, 32);
    check("full_wr_ready", wr_ready, 0);
    check("full_busy", busy, 0);
    tick();
    do_start(1);
    run_drain(1'b1);
    check("full_pass_beats", got_q.size(), 32);
    if (got_q.size() == 32) check("full_last_literal", got_q[31], 128'h120);

    // Reset while beat 2 of a replay is on the output.
    do_start(1);
    tick();
    tick();
    chk_en = 1'b0;
    exp_data_q.delete();
    exp_last_q.delete();
    done_due = 1'b0;
    prev_stall = 1'b0;
    RESET = 1'b0;
    tick();
    #3;
    check("midrst_valid", out_valid, 0);
    check("midrst_cen", CEN, 1);
    check("midrst_busy", busy, 0);
    check("midrst_fill", fill_count, 0);
    check("midrst_done", done, 0);
    check("midrst_wr_ready", wr_ready, 0);
    mdl_rows.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #3;
    check("midrst_release_wr_ready", wr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
